// File: rtl/msu_data_fetch.sv
// msu_data_fetch: prefetch buffer between the MSU register block data port and
// the HPS/SDRAM file reader. Fetches 16-bit little-endian words, queues them as
// bytes behind a head register and presents the byte at the current address.
module msu_data_fetch #(
    parameter int DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        seek,
    input  logic [31:0] seek_addr,
    input  logic        req,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_din
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ISSUE = CW'(DEPTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state_r;
    logic [31:0]     fetch_addr_r;
    logic            drop_lo_r;
    logic            seeked_r;
    logic            mem_rd_r;
    logic [31:0]     mem_addr_r;

    logic [7:0]      fifo_r [DEPTH];
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic [7:0]      head_r;
    logic            head_valid_r;
    logic [3:0]      skip_r;
    logic            busy_r;

    logic            arrival_s;
    logic [7:0]      head_n_s;
    logic            head_valid_n_s;
    logic [3:0]      skip_n_s;
    logic [AW-1:0]   rd_ptr_n_s;
    logic [AW-1:0]   wr_ptr_n_s;
    logic [CW-1:0]   count_n_s;
    logic            busy_n_s;
    logic [1:0]      byte_ok_s;
    logic [7:0]      byte_s     [2];
    logic [1:0]      push_en_s;
    logic [AW-1:0]   push_idx_s [2];
    logic [7:0]      push_dat_s [2];

    // A word is consumed only when it answers a live (non-flushed) request and no seek overrides it.
    assign arrival_s = (state_r == ST_WAIT) && mem_ack && !seek;

    // Fetch FSM: issues one word read at a time and discards the read in flight across a seek.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= ST_IDLE;
            fetch_addr_r <= 32'h0000_0000;
            drop_lo_r    <= 1'b0;
            seeked_r     <= 1'b0;
            mem_rd_r     <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
        end else if (seek) begin
            fetch_addr_r <= {seek_addr[31:1], 1'b0};
            drop_lo_r    <= seek_addr[0];
            seeked_r     <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    // FIFO is being cleared, so there is always room to start at once.
                    state_r    <= ST_WAIT;
                    mem_rd_r   <= 1'b1;
                    mem_addr_r <= {seek_addr[31:1], 1'b0};
                end
                ST_WAIT: begin
                    state_r <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (mem_ack) begin
                        state_r  <= ST_IDLE;
                        mem_rd_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    mem_rd_r <= 1'b0;
                end
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (seeked_r && (count_r <= CNT_ISSUE)) begin
                        state_r    <= ST_WAIT;
                        mem_rd_r   <= 1'b1;
                        mem_addr_r <= fetch_addr_r;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        state_r      <= ST_IDLE;
                        mem_rd_r     <= 1'b0;
                        fetch_addr_r <= fetch_addr_r + 32'd2;
                        drop_lo_r    <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (mem_ack) begin
                        state_r  <= ST_IDLE;
                        mem_rd_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    mem_rd_r <= 1'b0;
                end
            endcase
        end
    end

    // Next-state of head/FIFO/skip: consumer pop first, then the arriving bytes in address order.
    always_comb begin
        head_n_s       = head_r;
        head_valid_n_s = head_valid_r;
        skip_n_s       = skip_r;
        rd_ptr_n_s     = rd_ptr_r;
        wr_ptr_n_s     = wr_ptr_r;
        count_n_s      = count_r;
        push_en_s      = 2'b00;
        byte_s[0]      = mem_din[7:0];
        byte_s[1]      = mem_din[15:8];
        byte_ok_s      = {1'b1, !drop_lo_r};
        for (int i = 0; i < 2; i++) begin
            push_idx_s[i] = '0;
            push_dat_s[i] = 8'h00;
        end
        if (seek) begin
            head_valid_n_s = 1'b0;
            skip_n_s       = 4'd0;
            rd_ptr_n_s     = '0;
            wr_ptr_n_s     = '0;
            count_n_s      = '0;
        end else begin
            if (req && seeked_r) begin
                if (head_valid_r) begin
                    if (count_r != '0) begin
                        head_n_s   = fifo_r[rd_ptr_r];
                        rd_ptr_n_s = rd_ptr_r + PTR_ONE;
                        count_n_s  = count_r - CNT_ONE;
                    end else begin
                        // Underflow: data_out keeps the old byte until a new one loads.
                        head_valid_n_s = 1'b0;
                    end
                end else begin
                    // Consumer is ahead of the data: remember how many bytes to throw away.
                    skip_n_s = (skip_r != 4'd15) ? (skip_r + 4'd1) : skip_r;
                end
            end else begin
                skip_n_s = skip_r;
            end
            if (arrival_s) begin
                for (int i = 0; i < 2; i++) begin
                    if (byte_ok_s[i]) begin
                        if (skip_n_s != 4'd0) begin
                            skip_n_s = skip_n_s - 4'd1;
                        end else if (!head_valid_n_s) begin
                            head_n_s       = byte_s[i];
                            head_valid_n_s = 1'b1;
                        end else begin
                            push_en_s[i]  = 1'b1;
                            push_idx_s[i] = wr_ptr_n_s;
                            push_dat_s[i] = byte_s[i];
                            wr_ptr_n_s    = wr_ptr_n_s + PTR_ONE;
                            count_n_s     = count_n_s + CNT_ONE;
                        end
                    end else begin
                        push_en_s[i] = 1'b0;
                    end
                end
            end else begin
                push_en_s = 2'b00;
            end
        end
        // busy only reflects seek refills; a req underflow never raises it.
        busy_n_s = seek ? 1'b1 : (busy_r && !head_valid_n_s);
    end

    // Head, FIFO pointers, skip counter and busy flag registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_r       <= 8'h00;
            head_valid_r <= 1'b0;
            skip_r       <= 4'd0;
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            busy_r       <= 1'b0;
        end else begin
            head_r       <= head_n_s;
            head_valid_r <= head_valid_n_s;
            skip_r       <= skip_n_s;
            rd_ptr_r     <= rd_ptr_n_s;
            wr_ptr_r     <= wr_ptr_n_s;
            count_r      <= count_n_s;
            busy_r       <= busy_n_s;
        end
    end

    // FIFO storage: up to two byte writes per cycle into distinct slots.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int j = 0; j < DEPTH; j++) begin
                fifo_r[j] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_en_s[i]) begin
                    fifo_r[push_idx_s[i]] <= push_dat_s[i];
                end
            end
        end
    end

    assign data_out = head_r;
    assign busy     = busy_r;
    assign mem_rd   = mem_rd_r;
    assign mem_addr = mem_addr_r;

endmodule
